// File: rtl/serial_frame_loader_if.sv
// Frame-loader bus: upstream request/data, core status, and serial load outputs.
// master drives the request side; slave is the loader itself.
interface serial_frame_loader_if #(
  parameter int unsigned KEY_SIZE = 8,
  parameter int unsigned MSG_SIZE = 64
);
  logic                iEn;
  logic                iStart;
  logic [KEY_SIZE-1:0] iKey;
  logic [MSG_SIZE-1:0] iMsg;
  logic                iEncryption_status;
  logic                oReady;
  logic                oSerial_in;
  logic                oLoad_key;
  logic                oLoad_msg;
  logic                oDone;
  logic                oTimeout;

  modport master (
    output iEn, iStart, iKey, iMsg, iEncryption_status,
    input  oReady, oSerial_in, oLoad_key, oLoad_msg, oDone, oTimeout
  );

  modport slave (
    input  iEn, iStart, iKey, iMsg, iEncryption_status,
    output oReady, oSerial_in, oLoad_key, oLoad_msg, oDone, oTimeout
  );
endinterface

// File: rtl/serial_frame_loader.sv
// Serializes one key/message frame into the XOR core (key, gap, message),
// then waits for the core's completion flag or times out.
module serial_frame_loader #(
  parameter int unsigned KEY_SIZE       = 8,
  parameter int unsigned MSG_SIZE       = 64,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                  iClk,
  input logic                  iRst,
  serial_frame_loader_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(MSG_SIZE) + 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY,
    S_GAP,
    S_MSG,
    S_WAIT
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [TMO_W-1:0]    r_tmo, w_tmo_nxt, w_tmo_inc;
  logic [KEY_SIZE-1:0] r_key, w_key_nxt;
  logic [MSG_SIZE-1:0] r_msg, w_msg_nxt;
  logic                r_ready, w_ready;
  logic                r_serial, w_serial;
  logic                r_load_key, w_load_key;
  logic                r_load_msg, w_load_msg;
  logic                r_done, w_done;
  logic                r_timeout, w_timeout;

  // State and output registers; iEn low freezes everything, pending pulses included.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_tmo      <= '0;
      r_key      <= '0;
      r_msg      <= '0;
      r_ready    <= 1'b1;
      r_serial   <= 1'b0;
      r_load_key <= 1'b0;
      r_load_msg <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
    end else if (bus.iEn) begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_tmo      <= w_tmo_nxt;
      r_key      <= w_key_nxt;
      r_msg      <= w_msg_nxt;
      r_ready    <= w_ready;
      r_serial   <= w_serial;
      r_load_key <= w_load_key;
      r_load_msg <= w_load_msg;
      r_done     <= w_done;
      r_timeout  <= w_timeout;
    end
  end

  // Saturating WAIT-cycle count including the current cycle.
  assign w_tmo_inc = (r_tmo == TMO_W'(TIMEOUT_CYCLES)) ? r_tmo : r_tmo + TMO_W'(1);

  // Next-state and next-output logic; shadows shift left so the MSB is always the next bit.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tmo_nxt   = r_tmo;
    w_key_nxt   = r_key;
    w_msg_nxt   = r_msg;
    w_ready     = 1'b0;
    w_serial    = 1'b0;
    w_load_key  = 1'b0;
    w_load_msg  = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.iStart) begin
          w_key_nxt   = bus.iKey;
          w_msg_nxt   = bus.iMsg;
          w_cnt_nxt   = '0;
          w_ready     = 1'b0;
          w_state_nxt = S_KEY;
        end
      end

      S_KEY: begin
        w_load_key = 1'b1;
        w_serial   = r_key[KEY_SIZE-1];
        w_key_nxt  = r_key << 1;
        if (r_cnt == CNT_W'(KEY_SIZE - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_GAP;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      // Forces a falling edge on the key flag before the message flag rises.
      S_GAP: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_MSG;
      end

      S_MSG: begin
        w_load_msg = 1'b1;
        w_serial   = r_msg[MSG_SIZE-1];
        w_msg_nxt  = r_msg << 1;
        if (r_cnt == CNT_W'(MSG_SIZE - 1)) begin
          w_cnt_nxt   = '0;
          w_tmo_nxt   = '0;
          w_state_nxt = S_WAIT;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      // Completion takes priority over a coincident timeout.
      S_WAIT: begin
        if (bus.iEncryption_status) begin
          w_done      = 1'b1;
          w_ready     = 1'b1;
          w_tmo_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else if (w_tmo_inc == TMO_W'(TIMEOUT_CYCLES)) begin
          w_timeout   = 1'b1;
          w_ready     = 1'b1;
          w_tmo_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_tmo_nxt = w_tmo_inc;
        end
      end

      default: begin
        w_ready     = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.oReady     = r_ready;
  assign bus.oSerial_in = r_serial;
  assign bus.oLoad_key  = r_load_key;
  assign bus.oLoad_msg  = r_load_msg;
  assign bus.oDone      = r_done;
  assign bus.oTimeout   = r_timeout;

endmodule
